// File: rtl/bitstream_prefetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_prefetch_buffer_pkg
//  Description : Shared widths and FSM state encodings for the bitstream
//                prefetch buffer and its window extractor.
//  Revision    : 1.0  initial release
// ============================================================================
package bitstream_prefetch_buffer_pkg;

  // Datapath widths
  localparam int WORD_W       = 16;  // RAM word width
  localparam int ADDR_W       = 17;  // RAM word address width
  localparam int CNT_W        = 7;   // width of the bits_avail counter
  localparam int SHIFT_W      = 5;   // width of consume_len (0..16)
  localparam int BUF_BITS_DEF = 64;  // default shift-buffer capacity

  // Fetch FSM encodings
  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage : bitstream_prefetch_buffer_pkg
`default_nettype wire

// File: rtl/bitstream_prefetch_buffer_window.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_window_extract
//  Description : Purely combinational view of the MSB-aligned shift buffer:
//                presents the oldest 16 bits (zero padded), a mask of which
//                window bits are backed by real data, and the buffer with
//                a requested number of bits shifted out.
//  Revision    : 1.0  initial release
// ============================================================================
module bitstream_window_extract
  import bitstream_prefetch_buffer_pkg::*;
#(
  parameter int BUF_BITS = BUF_BITS_DEF
) (
  input  logic [BUF_BITS-1:0] buffer,
  input  logic [CNT_W-1:0]    bits_avail,
  input  logic [SHIFT_W-1:0]  shift_amt,
  output logic [WORD_W-1:0]   window,
  output logic [WORD_W-1:0]   pad_mask,
  output logic [BUF_BITS-1:0] shifted
);

  // Mask of window bits that hold real data; bit 0 set means a full word.
  always_comb begin
    pad_mask = {WORD_W{1'b1}};
    if (bits_avail < CNT_W'(WORD_W)) begin
      pad_mask = ~({WORD_W{1'b1}} >> bits_avail[3:0]);
    end
  end

  // Oldest bits sit at the top of the buffer; stale bits below are forced off.
  assign window  = buffer[BUF_BITS-1 -: WORD_W] & pad_mask;

  // Retiring bits is a left shift; vacated positions fill with zeros.
  assign shifted = buffer << shift_amt;

endmodule : bitstream_window_extract
`default_nettype wire

// File: rtl/bitstream_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_prefetch_buffer
//  Description : Prefetches 16-bit words from a word RAM into an MSB-aligned
//                shift buffer and presents the next 16 unconsumed bits to a
//                variable-length parser that retires 0..16 bits per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bitstream_prefetch_buffer
  import bitstream_prefetch_buffer_pkg::*;
#(
  parameter int BUF_BITS = BUF_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              BitStream_ram_ren,
  output logic [ADDR_W-1:0] BitStream_ram_addr,
  input  logic [WORD_W-1:0] BitStream_ram_data,
  input  logic [SHIFT_W-1:0] consume_len,
  output logic [WORD_W-1:0] window,
  output logic              window_valid,
  output logic [CNT_W-1:0]  bits_avail,
  output logic              stream_end,
  output logic              underflow_err
);

  // A new read may only go out if the buffer, every word still in flight and
  // the new word together leave one spare word of capacity.
  localparam logic [7:0] FILL_LIMIT = 8'(BUF_BITS - WORD_W);

  logic [ST_W-1:0]     state_q,      state_d;
  logic [ADDR_W-1:0]   addr_cnt_q,   addr_cnt_d;
  logic [ADDR_W-1:0]   end_addr_q,   end_addr_d;
  logic                rd_pending_q, rd_pending_d;
  logic                discard_q,    discard_d;
  logic [BUF_BITS-1:0] buf_q,        buf_d;
  logic [CNT_W-1:0]    bits_q,       bits_d;
  logic                uflow_q,      uflow_d;

  logic                issue;
  logic                capture;
  logic                underflow_now;
  logic                exhausted;
  logic [7:0]          fill_level;
  logic [SHIFT_W-1:0]  shift_amt;
  logic [CNT_W-1:0]    bits_kept;
  logic [BUF_BITS-1:0] shifted_buf;
  logic [BUF_BITS-1:0] append_word;
  logic [WORD_W-1:0]   pad_mask;

  bitstream_window_extract #(
    .BUF_BITS (BUF_BITS)
  ) u_window (
    .buffer     (buf_q),
    .bits_avail (bits_q),
    .shift_amt  (shift_amt),
    .window     (window),
    .pad_mask   (pad_mask),
    .shifted    (shifted_buf)
  );

  // Read issue decision, made from registered state so reset forces ren high at once.
  always_comb begin
    fill_level = {1'b0, bits_q} + (rd_pending_q ? 8'd16 : 8'd0) + 8'd16;
    issue      = (state_q == ST_RUN) && (addr_cnt_q <= end_addr_q) &&
                 (fill_level <= FILL_LIMIT);
  end

  // Consume/append datapath: retire first, then place the arriving word below what is left.
  always_comb begin
    underflow_now = ({2'b00, consume_len} > bits_q);
    shift_amt     = underflow_now ? '0 : consume_len;
    bits_kept     = bits_q - {2'b00, shift_amt};
    capture       = rd_pending_q && !discard_q;
    append_word   = {BitStream_ram_data, {(BUF_BITS-WORD_W){1'b0}}} >> bits_kept;
  end

  // Next-state logic for the fetch FSM and buffer; start overrides everything.
  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    end_addr_d   = end_addr_q;
    rd_pending_d = issue;
    discard_d    = 1'b0;
    buf_d        = shifted_buf | (capture ? append_word : '0);
    bits_d       = bits_kept + (capture ? CNT_W'(WORD_W) : '0);
    uflow_d      = uflow_q | underflow_now;

    case (state_q)
      ST_RUN: begin
        if (issue) begin
          // The last address is checked before incrementing, so the counter never wraps.
          if (addr_cnt_q == end_addr_q) begin
            state_d = ST_DRAIN;
          end else begin
            addr_cnt_d = addr_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((bits_q == '0) && !rd_pending_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (start) begin
      // An inverted range is an empty stream: skip straight to draining.
      state_d    = (start_addr > end_addr) ? ST_DRAIN : ST_RUN;
      addr_cnt_d = start_addr;
      end_addr_d = end_addr;
      buf_d      = '0;
      bits_d     = '0;
      uflow_d    = 1'b0;
      // Any read issued under the old stream returns next cycle and is dropped.
      discard_d  = 1'b1;
    end
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_cnt_q   <= '0;
      end_addr_q   <= '0;
      rd_pending_q <= 1'b0;
      discard_q    <= 1'b0;
      buf_q        <= '0;
      bits_q       <= '0;
      uflow_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      end_addr_q   <= end_addr_d;
      rd_pending_q <= rd_pending_d;
      discard_q    <= discard_d;
      buf_q        <= buf_d;
      bits_q       <= bits_d;
      uflow_q      <= uflow_d;
    end
  end

  // Fetching is over and nothing is still in flight.
  assign exhausted = (state_q != ST_RUN) && !rd_pending_q;

  assign BitStream_ram_ren  = ~issue;
  assign BitStream_ram_addr = addr_cnt_q;
  assign bits_avail         = bits_q;
  assign underflow_err      = uflow_q;
  // pad_mask[0] means a full word is buffered; pad_mask[MSB] means at least one bit.
  assign window_valid       = pad_mask[0] || (exhausted && pad_mask[WORD_W-1]);
  assign stream_end         = exhausted && (bits_q == '0);

endmodule : bitstream_prefetch_buffer
`default_nettype wire

// File: tb/tb_bitstream_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitstream_prefetch_buffer
//  Description : Self-checking bench: a bit-queue reference model compared
//                every cycle, plus directed scenarios with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bitstream_prefetch_buffer;

  localparam int BUF = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [16:0] start_addr = '0;
  logic [16:0] end_addr = '0;
  logic        ren;
  logic [16:0] ram_addr;
  logic [15:0] ram_data = '0;
  logic [4:0]  consume_len = '0;
  logic [15:0] window;
  logic        window_valid;
  logic [6:0]  bits_avail;
  logic        stream_end;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  logic [15:0] mem [0:511];

  bitstream_prefetch_buffer #(.BUF_BITS(BUF)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .BitStream_ram_ren  (ren),
    .BitStream_ram_addr (ram_addr),
    .BitStream_ram_data (ram_data),
    .consume_len        (consume_len),
    .window             (window),
    .window_valid       (window_valid),
    .bits_avail         (bits_avail),
    .stream_end         (stream_end),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  // Word RAM: data appears the cycle after a ren-low cycle.
  always @(posedge clk) if (!ren) ram_data <= mem[ram_addr[8:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: stream as a queue of bits ----------------
  bit          mq[$];
  bit          m_active, m_pend, m_discard, m_uflow;
  logic [16:0] m_next, m_end, m_pend_addr;

  function automatic bit model_issue();
    return m_active && (m_next <= m_end) &&
           (mq.size() + (m_pend ? 16 : 0) + 16 <= BUF - 16);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_active = 0; m_pend = 0; m_discard = 0; m_uflow = 0;
      m_next = '0; m_end = '0; m_pend_addr = '0;
    end else begin
      bit iss;
      iss = model_issue();
      if (start) begin
        mq.delete();
        m_pend      = iss;
        m_pend_addr = m_next;
        m_discard   = 1;
        m_uflow     = 0;
        m_next      = start_addr;
        m_end       = end_addr;
        m_active    = (start_addr <= end_addr);
      end else begin
        if (int'(consume_len) > mq.size()) m_uflow = 1;
        else for (int k = 0; k < int'(consume_len); k++) void'(mq.pop_front());
        if (m_pend && !m_discard) begin
          logic [15:0] w;
          w = mem[m_pend_addr[8:0]];
          for (int b = 15; b >= 0; b--) mq.push_back(w[b]);
        end
        m_discard   = 0;
        m_pend      = iss;
        m_pend_addr = m_next;
        if (iss) begin
          if (m_next == m_end) m_active = 0;
          else m_next = m_next + 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      logic [15:0] ew;
      bit          exh;
      ew = '0;
      for (int b = 0; b < 16; b++) if (b < mq.size()) ew[15-b] = mq[b];
      exh = !m_active && !m_pend;
      check("ren", ren, !model_issue());
      if (!ren) check("ram_addr", ram_addr, m_next);
      check("bits_avail", bits_avail, mq.size());
      check("window", window, ew);
      check("window_valid", window_valid, (mq.size() >= 16) || (exh && mq.size() > 0));
      check("stream_end", stream_end, exh && mq.size() == 0);
      check("underflow_err", underflow_err, m_uflow);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [16:0] sa, input logic [16:0] ea);
    start = 1'b1; start_addr = sa; end_addr = ea; consume_len = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_bits(input int target, input string name);
    for (int i = 0; i < 30 && int'(bits_avail) != target; i++) tick();
    check(name, bits_avail, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] got[$];
    int          maxb;
    for (int i = 0; i < 512; i++) mem[i] = 16'((i * 40503) ^ 16'h5A5A);
    mem[0] = 16'hA5C3; mem[5] = 16'hDEAD;
    mem[20] = 16'h8000; mem[21] = 16'hFFFF;
    mem[30] = 16'hABCD; mem[100] = 16'h1234;

    // Asynchronous reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_ren", ren, 1'b1);
    check("rst_addr", ram_addr, 17'd0);
    check("rst_bits", bits_avail, 7'd0);
    check("rst_window", window, 16'h0000);
    check("rst_valid", window_valid, 1'b0);
    check("rst_stream_end", stream_end, 1'b1);
    check("rst_uflow", underflow_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Startup fill: three back-to-back reads then hold
    start_stream(17'd0, 17'd7);
    check("fill_ren0", ren, 1'b0);  check("fill_addr0", ram_addr, 17'd0);
    tick();
    check("fill_ren1", ren, 1'b0);  check("fill_addr1", ram_addr, 17'd1);
    tick();
    check("fill_ren2", ren, 1'b0);  check("fill_addr2", ram_addr, 17'd2);
    check("fill_window", window, 16'hA5C3);
    check("fill_bits16", bits_avail, 7'd16);
    tick();
    check("fill_ren_hold", ren, 1'b1);
    repeat (4) tick();
    check("fill_bits48", bits_avail, 7'd48);
    check("fill_ren_idle", ren, 1'b1);

    // Steady streaming of 8 words
    start_stream(17'd0, 17'd7);
    maxb = 0;
    for (int c = 0; c < 200; c++) begin
      if (int'(bits_avail) > maxb) maxb = int'(bits_avail);
      if (bits_avail >= 7'd16) begin
        consume_len = 5'd16;
        got.push_back(window);
      end else begin
        consume_len = 5'd0;
      end
      tick();
      if (got.size() == 8 && stream_end) break;
    end
    consume_len = '0;
    check("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("stream_word", got[i], mem[i]);
    check("stream_max_le_64", maxb <= 64, 1'b1);
    check("stream_no_uflow", underflow_err, 1'b0);
    check("stream_end_high", stream_end, 1'b1);

    // Odd consumes
    start_stream(17'd20, 17'd21);
    wait_bits(32, "odd_fill");
    check("odd_window0", window, 16'h8000);
    consume_len = 5'd1; tick(); consume_len = '0;
    check("odd_window1", window, 16'h0001);
    check("odd_bits1", bits_avail, 7'd31);
    consume_len = 5'd3; tick(); consume_len = '0;
    check("odd_window2", window, 16'h000F);
    check("odd_bits2", bits_avail, 7'd28);

    // Single word, tail and underflow
    start_stream(17'd30, 17'd30);
    wait_bits(16, "tail_fill");
    check("tail_window0", window, 16'hABCD);
    consume_len = 5'd12; tick(); consume_len = '0;
    check("tail_bits4", bits_avail, 7'd4);
    check("tail_window", window, 16'hD000);
    check("tail_low12_zero", window[11:0], 12'h000);
    check("tail_valid", window_valid, 1'b1);
    consume_len = 5'd8; tick(); consume_len = '0;
    check("uflow_set", underflow_err, 1'b1);
    check("uflow_bits_kept", bits_avail, 7'd4);
    consume_len = 5'd4; tick(); consume_len = '0;
    check("tail_empty", bits_avail, 7'd0);
    check("tail_stream_end", stream_end, 1'b1);
    check("uflow_sticky", underflow_err, 1'b1);

    // Restart while an old read is returning
    start_stream(17'd5, 17'd10);
    check("rs_addr5", ram_addr, 17'd5);
    check("rs_ren5", ren, 1'b0);
    tick();
    start = 1'b1; start_addr = 17'd100; end_addr = 17'd103;
    tick();
    start = 1'b0;
    check("rs_uflow_clr", underflow_err, 1'b0);
    check("rs_bits0", bits_avail, 7'd0);
    for (int i = 0; i < 20 && !window_valid; i++) tick();
    check("rs_window100", window, 16'h1234);

    // Asynchronous reset mid-fetch
    tick();
    #3 reset_n = 1'b0;
    #1;
    check("ar_ren", ren, 1'b1);
    check("ar_bits", bits_avail, 7'd0);
    check("ar_window", window, 16'h0000);
    check("ar_stream_end", stream_end, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick();
    check("ar_after_bits", bits_avail, 7'd0);
    check("ar_after_ren", ren, 1'b1);

    // Inverted range: empty stream
    start_stream(17'd50, 17'd40);
    for (int i = 0; i < 4; i++) begin
      check("empty_ren", ren, 1'b1);
      tick();
    end
    check("empty_stream_end", stream_end, 1'b1);
    check("empty_bits", bits_avail, 7'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bitstream_prefetch_buffer
`default_nettype wire
